mem_port: RTL and testbench

//  Memory access port between the CPU load/store unit and the byte-wide ram.

---
 rtl/mem_port.sv | 127 ++++++++++++
 tb/tb_mem_port.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/mem_port.sv
// mem_port: byte/word CPU requests split into byte-wide ram transactions with ready handshake and timeout.
// Optional range check on request addresses: MEM_PORT_BOUNDS_CHECK_EN.
module mem_port #(
  parameter int ADDR_W  = 8,
  parameter int SIZE    = 256,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic              cpu_word,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [15:0]       cpu_wdata,
  output logic              cpu_busy,
  output logic              cpu_done,
  output logic [15:0]       cpu_rdata,
  output logic              cpu_err,
  output logic [ADDR_W-1:0] ram_address,
  output logic [7:0]        ram_wdata,
  input  logic [7:0]        ram_rdata,
  output logic              ram_read,
  output logic              ram_write,
  input  logic              ram_ready_r,
  input  logic              ram_ready_w
);
  typedef enum logic [2:0] {IDLE, ACC0, WAIT0, ACC1, WAIT1, FIN} state_t;
  if (SIZE < 1 || SIZE > (1 << ADDR_W) || TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_params
    $error("mem_port: SIZE or TIMEOUT out of range");
  end
  state_t            state_q;
  logic              we_q, word_q, busy_q, done_q, err_q, rd_q, wr_q;
  logic [ADDR_W-1:0] addr_q, ram_addr_q;
  logic [15:0]       wdata_q, rdata_q;
  logic [7:0]        lo_q, cnt_q, ram_wdata_q;
  logic              ready, reject;
  assign ready = we_q ? ram_ready_w : ram_ready_r;
`ifdef MEM_PORT_BOUNDS_CHECK_EN
  assign reject = (int'(cpu_addr) >= SIZE) || (cpu_word && int'(cpu_addr) + 1 >= SIZE);
`else
  assign reject = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      word_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      ram_addr_q  <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      lo_q        <= '0;
      cnt_q       <= '0;
      ram_wdata_q <= '0;
    end else begin
      rd_q   <= 1'b0;
      wr_q   <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          busy_q <= 1'b0;
          if (cpu_req && !busy_q) begin
            we_q    <= cpu_we;
            word_q  <= cpu_word;
            addr_q  <= cpu_addr;
            wdata_q <= cpu_wdata;
            busy_q  <= 1'b1;
            // A rejected request holds busy for one cycle alongside its err pulse.
            if (reject) err_q <= 1'b1;
            else begin
              state_q     <= ACC0;
              ram_addr_q  <= cpu_addr;
              ram_wdata_q <= cpu_wdata[7:0];
              rd_q        <= !cpu_we;
              wr_q        <= cpu_we;
            end
          end
        end
        ACC0, ACC1: begin
          state_q <= (state_q == ACC0) ? WAIT0 : WAIT1;
          cnt_q   <= '0;
        end
        WAIT0, WAIT1: begin
          if (ready) begin
            if (!we_q) begin
              if (state_q == WAIT0) begin
                lo_q <= ram_rdata;
                if (!word_q) rdata_q <= {8'h00, ram_rdata};
              end else rdata_q <= {ram_rdata, lo_q};
            end
            if (state_q == WAIT0 && word_q) begin
              state_q     <= ACC1;
              ram_addr_q  <= addr_q + ADDR_W'(1);
              ram_wdata_q <= wdata_q[15:8];
              rd_q        <= !we_q;
              wr_q        <= we_q;
            end else state_q <= FIN;
          end else if (cnt_q == 8'(TIMEOUT - 1)) begin
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else cnt_q <= cnt_q + 8'd1;
        end
        FIN: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign cpu_busy    = busy_q;
  assign cpu_done    = done_q;
  assign cpu_err     = err_q;
  assign cpu_rdata   = rdata_q;
  assign ram_address = ram_addr_q;
  assign ram_wdata   = ram_wdata_q;
  assign ram_read    = rd_q;
  assign ram_write   = wr_q;
endmodule

// File: tb/tb_mem_port.sv
// tb_mem_port: directed vector table plus hand-written multi-cycle sequences against a ram model.
module tb_mem_port;
  logic        clk = 1'b0, reset = 1'b1;
  logic        cpu_req = 1'b0, cpu_we = 1'b0, cpu_word = 1'b0;
  logic [7:0]  cpu_addr = '0;
  logic [15:0] cpu_wdata = '0;
  logic        cpu_busy, cpu_done, cpu_err;
  logic [15:0] cpu_rdata;
  logic [7:0]  ram_address, ram_wdata;
  logic [7:0]  ram_rdata = '0;
  logic        ram_read, ram_write;
  logic        ram_ready_r = 1'b0, ram_ready_w = 1'b0;
  logic        rd_en = 1'b1;
  logic [7:0]  mem [256];
  int          checks = 0, errors = 0, strobes = 0;

  mem_port #(.ADDR_W(8), .SIZE(256), .TIMEOUT(15)) dut (
    .clk(clk), .reset(reset), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_word(cpu_word),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_busy(cpu_busy), .cpu_done(cpu_done),
    .cpu_rdata(cpu_rdata), .cpu_err(cpu_err), .ram_address(ram_address), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .ram_read(ram_read), .ram_write(ram_write),
    .ram_ready_r(ram_ready_r), .ram_ready_w(ram_ready_w)
  );

  always #5 clk = ~clk;

  // ram model: ready one cycle after the strobe
  always @(posedge clk) begin
    ram_ready_r <= 1'b0;
    ram_ready_w <= 1'b0;
    if (reset) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
    end else begin
      if (ram_write) begin
        mem[ram_address] <= ram_wdata;
        ram_ready_w <= 1'b1;
      end
      if (ram_read) begin
        ram_rdata   <= mem[ram_address];
        ram_ready_r <= rd_en;
      end
    end
  end

  always @(negedge clk) begin
    if (ram_read || ram_write) strobes++;
    if (cpu_done && cpu_err) begin
      errors++;
      $display("FAIL done_err_overlap: done=%0b err=%0b required not both high", cpu_done, cpu_err);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run(input logic we, input logic word, input logic [7:0] addr, input logic [15:0] wd,
                     output int lat, output logic d, output logic e);
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = we; cpu_word = word; cpu_addr = addr; cpu_wdata = wd;
    lat = 0; d = 1'b0; e = 1'b0;
    for (int k = 1; k <= 40 && !d && !e; k++) begin
      @(posedge clk); #1;
      if (cpu_done) begin d = 1'b1; lat = k; end
      if (cpu_err) begin e = 1'b1; lat = k; end
    end
    cpu_req = 1'b0;
  endtask

  typedef struct {
    logic        we, word;
    logic [7:0]  addr;
    logic [15:0] wd, rd;
    int          lat;
    logic        err;
  } vec_t;
  vec_t tv[8];

  initial begin
    int lat, s0;
    logic d, e;
    tv[0] = '{1'b1, 1'b0, 8'h10, 16'h00A5, 16'h0000, 4, 1'b0};
    tv[1] = '{1'b0, 1'b0, 8'h10, 16'h0000, 16'h00A5, 4, 1'b0};
    tv[2] = '{1'b1, 1'b1, 8'h20, 16'hBEEF, 16'h00A5, 6, 1'b0};
    tv[3] = '{1'b0, 1'b1, 8'h20, 16'h0000, 16'hBEEF, 6, 1'b0};
    tv[4] = '{1'b0, 1'b0, 8'h21, 16'h0000, 16'h00BE, 4, 1'b0};
`ifdef MEM_PORT_BOUNDS_CHECK_EN
    tv[5] = '{1'b1, 1'b1, 8'hFF, 16'h1234, 16'h00BE, 1, 1'b1};
    tv[6] = '{1'b0, 1'b1, 8'hFF, 16'h0000, 16'h00BE, 1, 1'b1};
    tv[7] = '{1'b0, 1'b0, 8'h00, 16'h0000, 16'h0000, 4, 1'b0};
`else
    tv[5] = '{1'b1, 1'b1, 8'hFF, 16'h1234, 16'h00BE, 6, 1'b0};
    tv[6] = '{1'b0, 1'b1, 8'hFF, 16'h0000, 16'h1234, 6, 1'b0};
    tv[7] = '{1'b0, 1'b0, 8'h00, 16'h0000, 16'h0012, 4, 1'b0};
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", int'(cpu_busy), 0);
    chk("reset_done", int'(cpu_done), 0);
    chk("reset_err", int'(cpu_err), 0);
    chk("reset_rdata", int'(cpu_rdata), 0);
    chk("reset_strobes", int'({ram_read, ram_write}), 0);
    chk("reset_ram_addr", int'(ram_address), 0);
    chk("reset_ram_wdata", int'(ram_wdata), 0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 8; i++) begin
      s0 = strobes;
      run(tv[i].we, tv[i].word, tv[i].addr, tv[i].wd, lat, d, e);
      chk($sformatf("v%0d_err", i), int'(e), int'(tv[i].err));
      chk($sformatf("v%0d_done", i), int'(d), int'(!tv[i].err));
      chk($sformatf("v%0d_latency", i), lat, tv[i].lat);
      chk($sformatf("v%0d_rdata", i), int'(cpu_rdata), int'(tv[i].rd));
      chk($sformatf("v%0d_strobes", i), strobes - s0, tv[i].err ? 0 : (tv[i].word ? 2 : 1));
      chk($sformatf("v%0d_busy_end", i), int'(cpu_busy), int'(tv[i].err));
    end
    chk("mem_10", int'(mem[8'h10]), 'hA5);
    chk("mem_20", int'(mem[8'h20]), 'hEF);
    chk("mem_21", int'(mem[8'h21]), 'hBE);
`ifdef MEM_PORT_BOUNDS_CHECK_EN
    chk("mem_FF", int'(mem[8'hFF]), 'h00);
    chk("mem_00", int'(mem[8'h00]), 'h00);
`else
    chk("mem_FF", int'(mem[8'hFF]), 'h34);
    chk("mem_00", int'(mem[8'h00]), 'h12);
`endif

    // request held with a new address while busy
    @(negedge clk);
    s0 = strobes;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_word = 1'b0; cpu_addr = 8'h40;
    lat = 0;
    for (int k = 1; k <= 20 && lat == 0; k++) begin
      @(posedge clk); #1;
      if (k == 1) cpu_addr = 8'h50;
      if (cpu_done) lat = k;
    end
    chk("hold_latency", lat, 4);
    chk("hold_strobes", strobes - s0, 1);
    chk("hold_busy_at_done", int'(cpu_busy), 0);
    @(posedge clk); #1;
    chk("hold_second_busy", int'(cpu_busy), 1);
    chk("hold_second_read", int'(ram_read), 1);
    chk("hold_second_addr", int'(ram_address), 'h50);
    cpu_req = 1'b0;
    lat = 0;
    for (int k = 2; k <= 20 && lat == 0; k++) begin
      @(posedge clk); #1;
      if (cpu_done) lat = k;
    end
    chk("hold_second_latency", lat, 4);

    // ready never arrives
    rd_en = 1'b0;
    run(1'b0, 1'b0, 8'h10, 16'h0000, lat, d, e);
    chk("timeout_err", int'(e), 1);
    chk("timeout_done", int'(d), 0);
    chk("timeout_latency", lat, 17);
    chk("timeout_busy", int'(cpu_busy), 0);
    @(posedge clk); #1;
    chk("timeout_err_pulse", int'(cpu_err), 0);
    chk("timeout_idle_busy", int'(cpu_busy), 0);
    rd_en = 1'b1;

    // reset while in WAIT1 of a word load
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_word = 1'b1; cpu_addr = 8'h20;
    repeat (4) @(posedge clk);
    #1;
    chk("pre_reset_busy", int'(cpu_busy), 1);
    reset = 1'b1; cpu_req = 1'b0;
    @(posedge clk); #1;
    chk("midreset_busy", int'(cpu_busy), 0);
    chk("midreset_read", int'(ram_read), 0);
    chk("midreset_done", int'(cpu_done), 0);
    chk("midreset_err", int'(cpu_err), 0);
    chk("midreset_rdata", int'(cpu_rdata), 0);
    @(negedge clk);
    reset = 1'b0;
    run(1'b1, 1'b0, 8'h33, 16'h005A, lat, d, e);
    run(1'b0, 1'b0, 8'h33, 16'h0000, lat, d, e);
    chk("after_reset_done", int'(d), 1);
    chk("after_reset_latency", lat, 4);
    chk("after_reset_rdata", int'(cpu_rdata), 'h005A);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
